// File: rtl/ps2_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ps2_pkg : shared PS/2 receiver types, frame constants and scan codes |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_rx_state_t;

  localparam int PS2_DATA_BITS  = 8;
  localparam int PS2_FRAME_BITS = 11;

  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  localparam logic [7:0] PS2_EXTEND = 8'hE0;

  // Odd parity holds when the data bits plus the parity bit contain an odd count of ones.
  function automatic logic ps2_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ps2_sync_edge : PS/2 line synchroniser with registered clock fall    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module ps2_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clk_async_i,
  input  logic data_async_i,
  output logic clk_fall_o,
  output logic data_level_o
);

  // The extra top bit of the clock chain holds the previous synced level.
  logic [SYNC_STAGES:0]   clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   fall_q;

  // Lines idle high, so reset to 1 to avoid a spurious fall after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      fall_q      <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-1:0], clk_async_i};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], data_async_i};
      fall_q      <= clk_sync_q[SYNC_STAGES] & ~clk_sync_q[SYNC_STAGES-1];
    end
  end

  assign clk_fall_o   = fall_q;
  assign data_level_o = data_sync_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/ps2_receive.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ps2_receive : device-to-host PS/2 frame receiver with error pulses   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module ps2_receive
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       read_enable,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  output logic [7:0] received_data,
  output logic       received_valid,
  output logic       parity_error,
  output logic       frame_error,
  output logic       busy
);

  localparam int            CW            = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] c_timeout_m1  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    c_last_bit    = 3'(PS2_DATA_BITS - 1);

  logic clk_fall;
  logic data_sync;

  ps2_rx_state_t state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [CW-1:0] to_cnt_q, to_cnt_d;
  logic          parity_q, parity_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;

  ps2_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk          (clk),
    .reset        (reset),
    .clk_async_i  (ps2_clock),
    .data_async_i (ps2_data),
    .clk_fall_o   (clk_fall),
    .data_level_o (data_sync)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      to_cnt_q  <= '0;
      parity_q  <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      to_cnt_q  <= to_cnt_d;
      parity_q  <= parity_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    to_cnt_d  = to_cnt_q;
    parity_d  = parity_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;

    if (state_q != IDLE && !read_enable) begin
      // Command sender has taken the bus: abandon silently.
      state_d   = IDLE;
      bit_cnt_d = '0;
      to_cnt_d  = '0;
    end else if (state_q != IDLE && !clk_fall && to_cnt_q == c_timeout_m1) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      to_cnt_d  = '0;
      ferr_d    = 1'b1;
    end else begin
      if (state_q != IDLE) begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
      if (clk_fall) begin
        to_cnt_d = '0;
        case (state_q)
          IDLE: begin
            if (read_enable && !data_sync) begin
              state_d   = DATA;
              bit_cnt_d = '0;
              shift_d   = '0;
            end
          end
          DATA: begin
            shift_d[bit_cnt_q] = data_sync;
            bit_cnt_d          = bit_cnt_q + 3'd1;
            if (bit_cnt_q == c_last_bit) begin
              state_d = PARITY;
            end
          end
          PARITY: begin
            parity_d = data_sync;
            state_d  = STOP;
          end
          STOP: begin
            // A bad stop bit outranks a parity failure.
            if (!data_sync) begin
              ferr_d = 1'b1;
            end else if (ps2_parity_ok(shift_q, parity_q)) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              perr_d = 1'b1;
            end
            state_d = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  assign received_data  = data_q;
  assign received_valid = valid_q;
  assign parity_error   = perr_q;
  assign frame_error    = ferr_q;
  assign busy           = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ps2_receive.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ps2_receive : self-checking bench for ps2_receive                 |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_ps2_receive;
  import ps2_pkg::*;

  localparam int SYNC = 2;
  localparam int TO   = 300;
  localparam int HALF = 20;
  localparam int LAT  = SYNC + 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       read_enable;
  logic       ps2_clock;
  logic       ps2_data;
  logic [7:0] received_data;
  logic       received_valid;
  logic       parity_error;
  logic       frame_error;
  logic       busy;

  ps2_receive #(
    .SYNC_STAGES    (SYNC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .read_enable    (read_enable),
    .ps2_clock      (ps2_clock),
    .ps2_data       (ps2_data),
    .received_data  (received_data),
    .received_valid (received_valid),
    .parity_error   (parity_error),
    .frame_error    (frame_error),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_valid = 0, n_perr = 0, n_ferr = 0, n_multi = 0, busy_cycles = 0;
  int         last_valid_cyc = 0, last_perr_cyc = 0, last_ferr_cyc = 0;
  logic [7:0] last_valid_data = 8'h00;
  int         last_fall_cyc = 0;

  always @(negedge clk) begin
    if (received_valid) begin
      n_valid++;
      last_valid_cyc  = cyc;
      last_valid_data = received_data;
    end
    if (parity_error) begin
      n_perr++;
      last_perr_cyc = cyc;
    end
    if (frame_error) begin
      n_ferr++;
      last_ferr_cyc = cyc;
    end
    if (int'(received_valid) + int'(parity_error) + int'(frame_error) > 1) n_multi++;
    if (busy) busy_cycles++;
  end

  int         passes = 0;
  int         total  = 0;
  logic [7:0] exp_data = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference outcome: 0 = byte accepted, 1 = parity error, 2 = frame error.
  function automatic int model(input logic [7:0] b, input logic par, input logic stp);
    if (!stp) return 2;
    if ((($countones(b) + int'(par)) % 2) == 1) return 0;
    return 1;
  endfunction

  task automatic ps2_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (HALF / 2) @(negedge clk);
    ps2_clock     = 1'b0;
    last_fall_cyc = cyc;
    repeat (HALF) @(negedge clk);
    ps2_clock = 1'b1;
    repeat (HALF / 2) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic par, input logic stp, input int nbits);
    logic [10:0] f;
    f = {stp, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
    ps2_data = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic frame_check(input string tag, input logic [7:0] b, input logic par, input logic stp);
    int v0, p0, f0, o;
    v0 = n_valid; p0 = n_perr; f0 = n_ferr;
    o  = model(b, par, stp);
    send(b, par, stp, PS2_FRAME_BITS);
    check({tag, " valid"}, n_valid - v0, (o == 0) ? 1 : 0);
    check({tag, " perr"},  n_perr - p0,  (o == 1) ? 1 : 0);
    check({tag, " ferr"},  n_ferr - f0,  (o == 2) ? 1 : 0);
    if (o == 0) begin
      exp_data = b;
      check({tag, " pulse data"}, last_valid_data, b);
      check({tag, " latency"}, last_valid_cyc - last_fall_cyc, LAT);
    end else if (o == 1) begin
      check({tag, " latency"}, last_perr_cyc - last_fall_cyc, LAT);
    end else begin
      check({tag, " latency"}, last_ferr_cyc - last_fall_cyc, LAT);
    end
    check({tag, " data"}, received_data, exp_data);
    check({tag, " busy"}, busy, 1'b0);
  endtask

  initial begin
    int v0, p0, f0, b0;
    logic [7:0] rb;
    logic       rp, rs;

    reset = 1'b1; read_enable = 1'b1; ps2_clock = 1'b1; ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    check("reset data",  received_data,  8'h00);
    check("reset valid", received_valid, 1'b0);
    check("reset perr",  parity_error,   1'b0);
    check("reset ferr",  frame_error,    1'b0);
    check("reset busy",  busy,           1'b0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    frame_check("f1C", 8'h1C, 1'b0, 1'b1);
    frame_check("fF0", PS2_BREAK, 1'b1, 1'b1);
    frame_check("f1C_b2b", 8'h1C, 1'b0, 1'b1);
    frame_check("perr1C", 8'h1C, 1'b1, 1'b1);
    frame_check("f5A", 8'h5A, 1'b1, 1'b1);
    frame_check("stop00", 8'h00, 1'b1, 1'b0);
    frame_check("stop_par", 8'h00, 1'b0, 1'b0);

    // Timeout after four data bits.
    v0 = n_valid; f0 = n_ferr;
    send(8'h33, 1'b1, 1'b1, 5);
    check("to busy_mid", busy, 1'b1);
    repeat (TO + 40) @(negedge clk);
    check("to ferr",    n_ferr - f0, 1);
    check("to valid",   n_valid - v0, 0);
    check("to latency", last_ferr_cyc - last_fall_cyc, TO + LAT);
    check("to busy",    busy, 1'b0);
    frame_check("to_f5A", 8'h5A, 1'b1, 1'b1);

    // Bus owned by the command sender for a whole frame.
    v0 = n_valid; p0 = n_perr; f0 = n_ferr; b0 = busy_cycles;
    read_enable = 1'b0;
    send(8'h1C, 1'b0, 1'b1, PS2_FRAME_BITS);
    check("re0 pulses", (n_valid - v0) + (n_perr - p0) + (n_ferr - f0), 0);
    check("re0 busy",   busy_cycles - b0, 0);
    read_enable = 1'b1;
    repeat (5) @(negedge clk);

    // Reset after five data bits.
    send(8'h77, 1'b0, 1'b1, 6);
    check("rst busy_mid", busy, 1'b1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst data",  received_data,  8'h00);
    check("rst valid", received_valid, 1'b0);
    check("rst perr",  parity_error,   1'b0);
    check("rst ferr",  frame_error,    1'b0);
    check("rst busy",  busy,           1'b0);
    reset    = 1'b0;
    exp_data = 8'h00;
    repeat (5) @(negedge clk);
    frame_check("rst_f1C", 8'h1C, 1'b0, 1'b1);

    // read_enable dropped after three data bits.
    v0 = n_valid; p0 = n_perr; f0 = n_ferr;
    send(8'hA5, 1'b1, 1'b1, 4);
    check("drop busy_mid", busy, 1'b1);
    read_enable = 1'b0;
    @(negedge clk);
    check("drop busy", busy, 1'b0);
    repeat (TO + 20) @(negedge clk);
    check("drop pulses", (n_valid - v0) + (n_perr - p0) + (n_ferr - f0), 0);
    check("drop data", received_data, exp_data);
    read_enable = 1'b1;
    repeat (5) @(negedge clk);
    frame_check("fE0", PS2_EXTEND, 1'b0, 1'b1);

    for (int i = 0; i < 12; i++) begin
      rb = 8'($urandom);
      rs = ($urandom % 8) != 0;
      rp = ($countones(rb) % 2) == 0;
      if ($urandom % 4 == 0) rp = ~rp;
      frame_check($sformatf("rnd%0d", i), rb, rp, rs);
    end

    check("exclusive pulses", n_multi, 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ps2_receive.md
Name: ps2_receive

Overview:
- Device-to-host PS/2 receiver: the complement of the host-to-device command path.
- Samples the open-drain ps2_clock/ps2_data lines and deserialises 11-bit frames (start, 8 data bits LSB first, odd parity, stop).
- Presents each completed byte as a one-cycle valid pulse to the keyboard/mouse decode logic.
- Sits beside the command sender; read_enable arbitrates which block owns the bus.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on each PS/2 input before use; minimum 2.
- TIMEOUT_CYCLES, 50000: clk cycles without a ps2_clock falling edge mid-frame before the frame is aborted (1 ms at 50 MHz).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- read_enable  input  1  1 = receiver owns the bus; 0 = command sender active, so edges are ignored.
- ps2_clock  input  1  PS/2 clock line, asynchronous.
- ps2_data  input  1  PS/2 data line, asynchronous.
- received_data  output  8  last correctly received byte; holds its value between frames.
- received_valid  output  1  one-cycle pulse; received_data is updated in the same cycle.
- parity_error  output  1  one-cycle pulse when a frame fails odd parity.
- frame_error  output  1  one-cycle pulse on a bad stop bit or a timeout.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset values: received_data=0x00, received_valid=0, parity_error=0, frame_error=0, busy=0, state=IDLE, shift register=0, bit counter=0, timeout counter=0.
- Synchronisation: both inputs pass through SYNC_STAGES flops.
- Edge detection: a falling edge is the synced clock going 1→0 between consecutive cycles. Data is sampled from the synced data line in the same cycle the edge is detected.
- States: IDLE, DATA, PARITY, STOP.
- IDLE:
  - Edge with read_enable=1 and data=0 → DATA; clear bit counter and timeout counter.
  - Edge with data=1 (false start) → stay in IDLE, no error pulse.
  - Edge with read_enable=0 → ignored.
- DATA:
  - Each edge shifts data into bit[counter], LSB first.
  - After the 8th edge → PARITY.
- PARITY:
  - On the edge, latch the parity bit.
  - parity_ok = XOR of the 8 data bits and the parity bit == 1 (odd parity).
  - → STOP.
- STOP, on the edge:
  - data=1 and parity_ok: received_data ← byte and received_valid=1 in the next cycle.
  - data=1 and !parity_ok: parity_error=1 in the next cycle; received_data unchanged.
  - data=0: frame_error=1 in the next cycle. Stop-bit error takes priority if parity is also bad; only frame_error pulses.
  - All cases → IDLE.
- Latency: pulses assert SYNC_STAGES+2 clk cycles after the stop-bit falling edge at the pin (4 cycles at default) and last exactly 1 cycle.
- Timeout:
  - In any state other than IDLE, the counter increments every cycle and clears on each detected edge.
  - When it reaches TIMEOUT_CYCLES: frame_error=1 for one cycle, → IDLE, partial byte discarded.
- read_enable falls mid-frame: next cycle → IDLE, no error pulse, received_data unchanged.
- Reset mid-frame: all state returns to reset values. The next frame is received normally only if its start bit begins after reset deasserts.
- At most one of received_valid, parity_error, frame_error is high in any cycle.
- Counter widths: bit counter 3 bits; timeout counter $clog2(TIMEOUT_CYCLES+1) bits and never wraps.

Decomposition:
- Package ps2_pkg:
  - state enum ps2_rx_state_t {IDLE, DATA, PARITY, STOP}.
  - Constants PS2_DATA_BITS=8, PS2_FRAME_BITS=11.
  - Common scan-code constants: PS2_BREAK=8'hF0, PS2_EXTEND=8'hE0.
- One sub-module, ps2_sync_edge: parameterised synchroniser plus falling-edge detector. Outputs the synced level and a one-cycle fall pulse. Instantiated for ps2_clock; ps2_data uses its synced level only.

Test Plan:
- Valid frame: read_enable=1, PS/2 clock ≈12.5 kHz (4000 clk period), frame for 0x1C with parity=0, stop=1 → received_valid pulses once, received_data=0x1C, 4 cycles after the stop falling edge, no error pulses.
- Back-to-back frames: 0xF0 (parity 1) followed by 0x1C → two valid pulses with received_data 0xF0 then 0x1C; received_data holds 0xF0 between them.
- Parity error: 0x1C sent with parity=1 → parity_error one cycle, no received_valid, received_data keeps its previous value. Then a clean 0x5A (parity 1) → valid with 0x5A.
- Stop-bit error: 0x00 with parity=1, stop=0 → frame_error one cycle only, no parity_error, no valid.
- Timeout recovery: stop clocking after 4 data bits → frame_error exactly TIMEOUT_CYCLES cycles after the last edge, busy falls. A subsequent 0x5A frame is received correctly.
- Bus ownership and reset:
  - read_enable=0 for a whole 0x1C frame → no pulses, busy stays 0.
  - reset asserted after 5 data bits → all outputs at reset values.
  - read_enable dropped after 3 bits → IDLE with no pulses.
